// File: rtl/sprite_pkg.sv
// Shared widths, types and width helpers for the sprite layer engine.
package sprite_pkg;

  localparam int unsigned RGB_W   = 12;
  localparam int unsigned COORD_W = 10;
  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'hFFF;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               vis;
    logic               anim;
  } sprite_state_t;

  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned addr_w(input int unsigned frames, input int unsigned w,
                                         input int unsigned h);
    return $clog2(frames) + $clog2(h) + $clog2(w);
  endfunction

endpackage

// File: rtl/sprite_layer_engine_if.sv
// Shadow-register write port between game logic and the sprite layer engine.
interface sprite_layer_engine_if
  import sprite_pkg::*;
#(
  parameter int unsigned SEL_W = 2
);
  logic               wr_en;
  logic [SEL_W-1:0]   wr_sel;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic               wr_vis;
  logic               wr_anim;

  modport master (output wr_en, wr_sel, wr_x, wr_y, wr_vis, wr_anim);
  modport slave  (input  wr_en, wr_sel, wr_x, wr_y, wr_vis, wr_anim);
endinterface

// File: rtl/sprite_layer_engine_channel.sv
// One sprite channel: shadow/active state, frame counter, hit test and ROM address.
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned H      = 32,
  parameter int unsigned FRAMES = 4,
  parameter int unsigned AW     = addr_w(FRAMES, W, H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  sprite_state_t      wr_state_i,
  input  logic               commit_i,
  input  logic               anim_step_i,
  input  logic               bright_i,
  input  logic [COORD_W-1:0] hcount_i,
  input  logic [COORD_W-1:0] vcount_i,
  output logic               in_o,
  output logic [AW-1:0]      rom_addr_o
);

  localparam int unsigned COL_W   = $clog2(W);
  localparam int unsigned ROW_W   = $clog2(H);
  localparam int unsigned FRAME_W = $clog2(FRAMES);
  localparam int unsigned CMP_W   = COORD_W + 1;

  sprite_state_t shadow_q, shadow_d;
  sprite_state_t active_q, active_d;

  // Commit copies the pre-write shadow, so a same-cycle write waits a frame.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (commit_i) active_d = shadow_q;
    if (wr_en_i)  shadow_d = wr_state_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // One extra bit so a box hanging past column 1023 clips instead of wrapping.
  logic [CMP_W-1:0] h_ext, v_ext, x_ext, y_ext;
  assign h_ext = CMP_W'(hcount_i);
  assign v_ext = CMP_W'(vcount_i);
  assign x_ext = CMP_W'(active_q.x);
  assign y_ext = CMP_W'(active_q.y);

  assign in_o = active_q.vis && bright_i &&
                (h_ext >= x_ext) && (h_ext < x_ext + CMP_W'(W)) &&
                (v_ext >= y_ext) && (v_ext < y_ext + CMP_W'(H));

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  assign col = COL_W'(hcount_i - active_q.x);
  assign row = ROW_W'(vcount_i - active_q.y);

  generate
    if (FRAME_W > 0) begin : g_anim
      logic [FRAME_W-1:0] frame_q, frame_d;

      always_comb begin
        frame_d = frame_q;
        if (commit_i && anim_step_i && active_q.anim) frame_d = frame_q + FRAME_W'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) frame_q <= '0;
        else     frame_q <= frame_d;
      end

      assign rom_addr_o = {frame_q, row, col};
    end else begin : g_static
      assign rom_addr_o = {row, col};
    end
  endgenerate

endmodule

// File: rtl/sprite_layer_engine.sv
// Overlays NUM_SPRITES colour-keyed, animated sprites on the background pixel stream.
module sprite_layer_engine
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned W           = 32,
  parameter int unsigned H           = 32,
  parameter int unsigned FRAMES      = 4,
  parameter int unsigned ANIM_DIV    = 8,
  parameter logic [RGB_W-1:0] KEY_COLOR = KEY_COLOR_DEF,
  parameter int unsigned V_COMMIT    = 480,
  localparam int unsigned SEL_W      = sel_w(NUM_SPRITES),
  localparam int unsigned AW         = addr_w(FRAMES, W, H)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bright,
  input  logic [COORD_W-1:0]            hCount,
  input  logic [COORD_W-1:0]            vCount,
  input  logic [RGB_W-1:0]              background,
  sprite_layer_engine_if.slave          wr_if,
  output logic [NUM_SPRITES*AW-1:0]     rom_addr,
  input  logic [NUM_SPRITES*RGB_W-1:0]  rom_data,
  output logic [RGB_W-1:0]              rgb,
  output logic [SEL_W-1:0]              hit_id,
  output logic                          hit_valid,
  output logic                          collision
);

  localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [COORD_W-1:0] vcount_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               commit_c, anim_step_c;

  assign commit_c    = (vCount == COORD_W'(V_COMMIT)) && (vcount_q != COORD_W'(V_COMMIT));
  assign anim_step_c = (div_q == DIV_W'(ANIM_DIV - 1));

  always_comb begin
    div_d = div_q;
    if (commit_c) div_d = anim_step_c ? '0 : div_q + DIV_W'(1);
  end

  sprite_state_t          wr_state_c;
  logic [NUM_SPRITES-1:0] in_c;

  assign wr_state_c = '{x: wr_if.wr_x, y: wr_if.wr_y, vis: wr_if.wr_vis, anim: wr_if.wr_anim};

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
    sprite_channel #(
      .W      (W),
      .H      (H),
      .FRAMES (FRAMES),
      .AW     (AW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr_en_i     (wr_if.wr_en && (wr_if.wr_sel == SEL_W'(g))),
      .wr_state_i  (wr_state_c),
      .commit_i    (commit_c),
      .anim_step_i (anim_step_c),
      .bright_i    (bright),
      .hcount_i    (hCount),
      .vcount_i    (vCount),
      .in_o        (in_c[g]),
      .rom_addr_o  (rom_addr[g*AW +: AW])
    );
  end

  logic [NUM_SPRITES-1:0] in_q;
  logic                   bright_q;
  logic [RGB_W-1:0]       bg_q;

  // Stage 1 resolve: lowest opaque index wins; a second opaque hit flags overlap.
  logic             found_c, multi_c;
  logic [SEL_W-1:0] win_c;
  logic [RGB_W-1:0] pix_c;

  always_comb begin
    found_c = 1'b0;
    multi_c = 1'b0;
    win_c   = '0;
    pix_c   = '0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      if (in_q[s] && (rom_data[s*RGB_W +: RGB_W] != KEY_COLOR)) begin
        if (found_c) begin
          multi_c = 1'b1;
        end else begin
          found_c = 1'b1;
          win_c   = SEL_W'(s);
          pix_c   = rom_data[s*RGB_W +: RGB_W];
        end
      end
    end
  end

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [SEL_W-1:0] hit_id_q, hit_id_d;
  logic             hit_valid_q, hit_valid_d;
  logic             coll_q, coll_d, acc_q, acc_d;

  always_comb begin
    rgb_d       = bright_q ? (found_c ? pix_c : bg_q) : '0;
    hit_valid_d = found_c;
    hit_id_d    = win_c;
    coll_d      = coll_q;
    acc_d       = acc_q | multi_c;
    if (commit_c) begin
      coll_d = acc_q;
      acc_d  = multi_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vcount_q    <= '0;
      div_q       <= '0;
      in_q        <= '0;
      bright_q    <= 1'b0;
      bg_q        <= '0;
      rgb_q       <= '0;
      hit_id_q    <= '0;
      hit_valid_q <= 1'b0;
      coll_q      <= 1'b0;
      acc_q       <= 1'b0;
    end else begin
      vcount_q    <= vCount;
      div_q       <= div_d;
      in_q        <= in_c;
      bright_q    <= bright;
      bg_q        <= background;
      rgb_q       <= rgb_d;
      hit_id_q    <= hit_id_d;
      hit_valid_q <= hit_valid_d;
      coll_q      <= coll_d;
      acc_q       <= acc_d;
    end
  end

  assign rgb       = rgb_q;
  assign hit_id    = hit_id_q;
  assign hit_valid = hit_valid_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_sprite_layer_engine.sv
// Bench for sprite_layer_engine: directed scenarios plus randomized traffic vs a pixel-level model.
module tb_sprite_layer_engine;
  import sprite_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, bright;
  logic [9:0]        hCount, vCount;
  logic [11:0]       background;
  logic [NS*AW-1:0]  rom_addr;
  logic [NS*12-1:0]  rom_data;
  logic [11:0]       rgb;
  logic [1:0]        hit_id;
  logic              hit_valid, collision;

  sprite_layer_engine_if #(.SEL_W(2)) wr_if ();

  sprite_layer_engine dut (
    .clk        (clk),
    .rst        (rst),
    .bright     (bright),
    .hCount     (hCount),
    .vCount     (vCount),
    .background (background),
    .wr_if      (wr_if),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rgb        (rgb),
    .hit_id     (hit_id),
    .hit_valid  (hit_valid),
    .collision  (collision)
  );

  // External sprite ROMs, one clock of read latency.
  logic [11:0] rom_mem [NS][4096];
  always @(posedge clk)
    for (int s = 0; s < NS; s++) rom_data[s*12 +: 12] <= rom_mem[s][rom_addr[s*AW +: AW]];

  // Reference state of the whole layer, in plain integers.
  int   sh_x [NS], sh_y [NS], ac_x [NS], ac_y [NS], fr [NS];
  bit   sh_vis [NS], sh_anim [NS], ac_vis [NS], ac_anim [NS];
  int   dv, prev_vc, e1_id, e2_id;
  bit   m_coll, m_acc, m_prev, e1_hv, e2_hv;
  logic [11:0] e1_rgb, e2_rgb;
  int   n_pass = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic eval_px(output logic [11:0] c, output bit hv, output int id, output int cnt);
    int hc, vc;
    logic [11:0] pix;
    hc = int'(hCount);
    vc = int'(vCount);
    c = bright ? background : 12'h000;
    hv = 0; id = 0; cnt = 0;
    for (int s = 0; s < NS; s++) begin
      if (ac_vis[s] && bright && hc >= ac_x[s] && hc < ac_x[s] + 32 &&
          vc >= ac_y[s] && vc < ac_y[s] + 32) begin
        pix = rom_mem[s][fr[s]*1024 + (vc - ac_y[s])*32 + (hc - ac_x[s])];
        if (pix != 12'hFFF) begin
          cnt++;
          if (cnt == 1) begin c = pix; hv = 1; id = s; end
        end
      end
    end
  endtask

  task automatic model_edge();
    logic [11:0] c;
    bit hv, commit;
    int id, cnt;
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        sh_x[s] = 0; sh_y[s] = 0; sh_vis[s] = 0; sh_anim[s] = 0;
        ac_x[s] = 0; ac_y[s] = 0; ac_vis[s] = 0; ac_anim[s] = 0; fr[s] = 0;
      end
      dv = 0; prev_vc = 0; m_coll = 0; m_acc = 0; m_prev = 0;
      e1_rgb = 0; e1_hv = 0; e1_id = 0; e2_rgb = 0; e2_hv = 0; e2_id = 0;
    end else begin
      commit = (vCount == 10'd480) && (prev_vc != 480);
      eval_px(c, hv, id, cnt);
      e2_rgb = e1_rgb; e2_hv = e1_hv; e2_id = e1_id;
      e1_rgb = c; e1_hv = hv; e1_id = id;
      if (commit) begin m_coll = m_acc; m_acc = m_prev; end
      else m_acc = m_acc | m_prev;
      m_prev = (cnt >= 2);
      if (commit) begin
        if (dv == 7)
          for (int s = 0; s < NS; s++) if (ac_anim[s]) fr[s] = (fr[s] + 1) % 4;
        dv = (dv + 1) % 8;
        for (int s = 0; s < NS; s++) begin
          ac_x[s] = sh_x[s]; ac_y[s] = sh_y[s]; ac_vis[s] = sh_vis[s]; ac_anim[s] = sh_anim[s];
        end
      end
      if (wr_if.wr_en) begin
        sh_x[wr_if.wr_sel] = int'(wr_if.wr_x);     sh_y[wr_if.wr_sel] = int'(wr_if.wr_y);
        sh_vis[wr_if.wr_sel] = wr_if.wr_vis;       sh_anim[wr_if.wr_sel] = wr_if.wr_anim;
      end
      prev_vc = int'(vCount);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rgb", 32'(rgb), 32'(e2_rgb));
    chk("hit_valid", 32'(hit_valid), 32'(e2_hv));
    chk("hit_id", 32'(hit_id), 32'(e2_id));
    chk("collision", 32'(collision), 32'(m_coll));
  endtask

  task automatic set_px(input int hc, input int vc, input bit br, input logic [11:0] bg);
    hCount = 10'(hc); vCount = 10'(vc); bright = br; background = bg;
  endtask

  task automatic probe(input int hc, input int vc, input bit br, input logic [11:0] bg);
    set_px(hc, vc, br, bg);
    tick();
    tick();
  endtask

  task automatic expect_px(input string tag, input logic [11:0] c, input bit hv, input int id);
    chk({tag, ".rgb"}, 32'(rgb), 32'(c));
    chk({tag, ".hit_valid"}, 32'(hit_valid), 32'(hv));
    chk({tag, ".hit_id"}, 32'(hit_id), 32'(id));
  endtask

  task automatic write_spr(input int s, input int x, input int y, input bit vis, input bit anim);
    wr_if.wr_sel = 2'(s); wr_if.wr_x = 10'(x); wr_if.wr_y = 10'(y);
    wr_if.wr_vis = vis; wr_if.wr_anim = anim; wr_if.wr_en = 1'b1;
    tick();
    wr_if.wr_en = 1'b0;
  endtask

  task automatic commit_frame();
    set_px(0, 0, 1, 12'h555);
    tick();
    vCount = 10'd480;
    tick();
    vCount = 10'd0;
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] exp_pix;
    logic [1:0]  f1, f3;
    int r, s, hc, vc;

    for (int i = 0; i < NS; i++)
      for (int a = 0; a < 4096; a++) rom_mem[i][a] = 12'h000;
    rst = 1'b1; set_px(0, 0, 0, 12'h000);
    wr_if.wr_en = 1'b0; wr_if.wr_sel = 2'd0; wr_if.wr_x = '0; wr_if.wr_y = '0;
    wr_if.wr_vis = 1'b0; wr_if.wr_anim = 1'b0;
    tick();
    tick();
    expect_px("reset", 12'h000, 0, 0);
    chk("reset.collision", 32'(collision), 32'd0);
    rst = 1'b0;

    // 1: single sprite, key colour in column 0, box edges
    for (int a = 0; a < 4096; a++) rom_mem[0][a] = (a % 32 == 0) ? 12'hFFF : 12'h0F0;
    write_spr(0, 100, 50, 1, 0);
    commit_frame();
    probe(100, 50, 1, 12'hABC); expect_px("t1.keyed_col0", 12'hABC, 0, 0);
    probe(101, 50, 1, 12'hABC); expect_px("t1.opaque",     12'h0F0, 1, 0);
    probe(131, 81, 1, 12'hABC); expect_px("t1.last_px",    12'h0F0, 1, 0);
    probe(132, 50, 1, 12'hABC); expect_px("t1.right_out",  12'hABC, 0, 0);
    probe(131, 82, 1, 12'hABC); expect_px("t1.bottom_out", 12'hABC, 0, 0);
    probe(99, 50, 1, 12'hABC);  expect_px("t1.left_out",   12'hABC, 0, 0);

    // 2: priority and collision
    for (int a = 0; a < 4096; a++) begin rom_mem[0][a] = 12'hF00; rom_mem[2][a] = 12'h00F; end
    write_spr(0, 200, 200, 1, 0);
    write_spr(2, 190, 195, 1, 0);
    commit_frame();
    probe(200, 200, 1, 12'h111); expect_px("t2.prio0", 12'hF00, 1, 0);
    commit_frame();
    chk("t2.collision_set", 32'(collision), 32'd1);
    rom_mem[0][0] = 12'hFFF;
    probe(200, 200, 1, 12'h111); expect_px("t2.prio2", 12'h00F, 1, 2);
    commit_frame();
    chk("t2.collision_clr", 32'(collision), 32'd0);

    // 3: write in the commit cycle waits one frame
    for (int a = 0; a < 4096; a++) rom_mem[3][a] = 12'h123;
    write_spr(3, 500, 300, 1, 0);
    commit_frame();
    probe(505, 305, 1, 12'h222); expect_px("t3.before", 12'h123, 1, 3);
    set_px(0, 0, 1, 12'h222);
    tick();
    wr_if.wr_sel = 2'd3; wr_if.wr_x = 10'd300; wr_if.wr_y = 10'd300;
    wr_if.wr_vis = 1'b1; wr_if.wr_anim = 1'b0; wr_if.wr_en = 1'b1;
    vCount = 10'd480;
    tick();
    wr_if.wr_en = 1'b0; vCount = 10'd0;
    tick();
    probe(505, 305, 1, 12'h222); expect_px("t3.old_pos", 12'h123, 1, 3);
    probe(305, 305, 1, 12'h222); expect_px("t3.new_pos_hidden", 12'h222, 0, 0);
    commit_frame();
    probe(305, 305, 1, 12'h222); expect_px("t3.new_pos", 12'h123, 1, 3);
    probe(505, 305, 1, 12'h222); expect_px("t3.old_pos_gone", 12'h222, 0, 0);

    // 4: animation every 8 commits
    pulse_reset();
    for (int a = 0; a < 4096; a++) rom_mem[1][a] = 12'($urandom_range(0, 12'hFFE));
    write_spr(1, 600, 100, 1, 1);
    write_spr(3, 700, 100, 1, 0);
    for (int k = 1; k <= 32; k++) begin
      commit_frame();
      f1 = rom_addr[23:22];
      chk("t4.frame_anim", 32'(f1), 32'((k / 8) % 4));
      if (k % 8 == 0) begin
        f3 = rom_addr[47:46];
        chk("t4.frame_static", 32'(f3), 32'd0);
        probe(610, 110, 1, 12'h333);
      end
    end

    // 5: right-edge clipping and blanking
    for (int a = 0; a < 4096; a++) rom_mem[2][a] = 12'($urandom_range(0, 12'hFFE));
    write_spr(2, 1010, 400, 1, 0);
    commit_frame();
    exp_pix = rom_mem[2][13];
    probe(1023, 400, 1, 12'h444); expect_px("t5.col1023", exp_pix, 1, 2);
    exp_pix = rom_mem[2][31*32];
    probe(1010, 431, 1, 12'h444); expect_px("t5.left_bottom", exp_pix, 1, 2);
    probe(1009, 400, 1, 12'h444); expect_px("t5.left_out", 12'h444, 0, 0);
    probe(0, 400, 1, 12'h444);    expect_px("t5.no_wrap0", 12'h444, 0, 0);
    probe(5, 400, 1, 12'h444);    expect_px("t5.no_wrap5", 12'h444, 0, 0);
    probe(1015, 400, 0, 12'h444); expect_px("t5.dark", 12'h000, 0, 0);

    // 6: reset mid-line with a sprite shown and collision pending
    write_spr(0, 1000, 400, 1, 0);
    commit_frame();
    probe(1015, 405, 1, 12'h666); expect_px("t6.shown", 12'hF00, 1, 0);
    commit_frame();
    chk("t6.collision_pre", 32'(collision), 32'd1);
    set_px(1015, 405, 1, 12'h666);
    tick();
    pulse_reset();
    expect_px("t6.after_rst", 12'h000, 0, 0);
    chk("t6.collision_rst", 32'(collision), 32'd0);
    probe(1015, 405, 1, 12'h666); expect_px("t6.gone", 12'h666, 0, 0);
    commit_frame();
    probe(1015, 405, 1, 12'h666); expect_px("t6.still_gone", 12'h666, 0, 0);
    write_spr(0, 1000, 400, 1, 0);
    commit_frame();
    probe(1015, 405, 1, 12'h666); expect_px("t6.back", 12'hF00, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < NS; i++)
      for (int a = 0; a < 4096; a++)
        rom_mem[i][a] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 12'hFFE));
    for (int it = 0; it < 2500; it++) begin
      r = int'($urandom_range(0, 99));
      s = int'($urandom_range(0, NS - 1));
      hc = ac_x[s] + int'($urandom_range(0, 37)) - 3;
      vc = ac_y[s] + int'($urandom_range(0, 37)) - 3;
      if (hc < 0) hc = 0;
      if (hc > 1023) hc = 1023;
      if (vc < 0) vc = 0;
      if (vc > 1023) vc = 1023;
      set_px(hc, vc, $urandom_range(0, 9) != 0, 12'($urandom));
      if (r < 10) begin
        wr_if.wr_sel = 2'($urandom_range(0, NS - 1));
        wr_if.wr_x = 10'($urandom_range(0, 1023)); wr_if.wr_y = 10'($urandom_range(0, 500));
        wr_if.wr_vis = ($urandom_range(0, 3) != 0); wr_if.wr_anim = 1'($urandom);
        wr_if.wr_en = 1'b1;
      end
      if (r >= 8 && r < 14) vCount = 10'd480;
      if (r == 99) rst = 1'b1;
      tick();
      wr_if.wr_en = 1'b0;
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
